// File: rtl/lfsr_seq_gen.sv
// Fibonacci LFSR bit-stream generator with seed load, zero-seed protection and
// period measurement; MSB is the stream, cycle_done marks a return to the start seed.
module lfsr_seq_gen #(
  parameter int unsigned          WIDTH        = 22,
  parameter logic [WIDTH-1:0]     TAPS         = WIDTH'(22'h200001),
  parameter logic [WIDTH-1:0]     DEFAULT_SEED = WIDTH'(22'h000001)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             MSB,
  output logic             cycle_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] plen_d;
  logic             lock_d;
  logic             cd_d;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] cnt_inc;

  assign fb       = ^(q & TAPS);
  assign step_val = {q[WIDTH-2:0], fb};
  assign cnt_inc  = cnt_q + WIDTH'(1);
  assign MSB      = q[WIDTH-1];

  // Next-state: load overrides everything; a step landing on start_seed closes a period.
  always_comb begin
    state_d = state_q;
    q_d     = q;
    start_d = start_q;
    cnt_d   = cnt_q;
    plen_d  = period_len;
    lock_d  = lockup;
    cd_d    = 1'b0;

    if (load) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (seed == '0) begin
        q_d     = DEFAULT_SEED;
        start_d = DEFAULT_SEED;
        lock_d  = 1'b1;
      end else begin
        q_d     = seed;
        start_d = seed;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
        end
        RUN: begin
          if (en) begin
            q_d = step_val;
            if (step_val == start_q) begin
              cd_d   = 1'b1;
              plen_d = cnt_inc;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      q          <= DEFAULT_SEED;
      start_q    <= DEFAULT_SEED;
      cnt_q      <= '0;
      period_len <= '0;
      lockup     <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      q          <= q_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      period_len <= plen_d;
      lockup     <= lock_d;
      cycle_done <= cd_d;
    end
  end

endmodule
